// File: rtl/bip_seq_control.sv
// bip_seq_control: fetch/execute sequencer for a BIP-style accumulator core.
//   clk_i, rst_i (async, active-low)
//   rom_*       : instruction fetch handshake (req held until ack, data valid with ack)
//   z_i, n_i    : accumulator zero / negative flags, sampled in EXEC
//   operand_o, sela_o, selb_o, op_o : datapath selects, decoded from IR in every state
//   wracc_o, wrram_o, enram_o       : datapath strobes, only ever high in EXEC
//   halted_o    : core stopped on HLT (absorbing until reset)
module bip_seq_control #(
  parameter int INSTR_W = 16,
  parameter int OPC_W   = 5,
  parameter int ADDR_W  = 11
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  output logic [ADDR_W-1:0]          rom_addr_o,
  output logic                       rom_req_o,
  input  logic                       rom_ack_i,
  input  logic [INSTR_W-1:0]         rom_data_i,
  input  logic                       z_i,
  input  logic                       n_i,
  output logic [INSTR_W-OPC_W-1:0]   operand_o,
  output logic [1:0]                 sela_o,
  output logic                       selb_o,
  output logic                       op_o,
  output logic                       wracc_o,
  output logic                       wrram_o,
  output logic                       enram_o,
  output logic                       halted_o
);
  localparam int OPR_W = INSTR_W - OPC_W;

  // Branch targets come from the low operand bits, so the PC cannot be wider.
  if (ADDR_W > OPR_W) begin : g_bad_addr_w
    $error("bip_seq_control: ADDR_W must not exceed INSTR_W-OPC_W");
  end

  localparam logic [OPC_W-1:0] OP_HLT  = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_STO  = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_SUBI = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_BNE  = OPC_W'(9);
  localparam logic [OPC_W-1:0] OP_BGT  = OPC_W'(10);
  localparam logic [OPC_W-1:0] OP_BGE  = OPC_W'(11);
  localparam logic [OPC_W-1:0] OP_BLT  = OPC_W'(12);
  localparam logic [OPC_W-1:0] OP_BLE  = OPC_W'(13);
  localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(14);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic [OPC_W-1:0]     opc;
  logic                 taken;
  logic                 wracc, wrram, enram;

  assign opc        = ir_q[INSTR_W-1 -: OPC_W];
  assign operand_o  = ir_q[OPR_W-1:0];
  assign rom_addr_o = pc_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Datapath selects and raw strobes from the IR; strobes gated by state below.
  always_comb begin
    sela_o = 2'b00;
    selb_o = 1'b0;
    op_o   = 1'b0;
    wracc  = 1'b0;
    wrram  = 1'b0;
    enram  = 1'b0;
    case (opc)
      OP_STO:  wrram = 1'b1;
      OP_LD:   begin enram = 1'b1; wracc = 1'b1; end
      OP_LDI:  begin wracc = 1'b1; sela_o = 2'b01; end
      OP_ADD:  begin enram = 1'b1; wracc = 1'b1; sela_o = 2'b10; end
      OP_ADDI: begin selb_o = 1'b1; wracc = 1'b1; sela_o = 2'b10; end
      OP_SUB:  begin enram = 1'b1; wracc = 1'b1; sela_o = 2'b10; op_o = 1'b1; end
      OP_SUBI: begin selb_o = 1'b1; wracc = 1'b1; sela_o = 2'b10; op_o = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (opc)
      OP_BEQ:  taken = z_i;
      OP_BNE:  taken = !z_i;
      OP_BGT:  taken = !z_i && !n_i;
      OP_BGE:  taken = !n_i;
      OP_BLT:  taken = n_i;
      OP_BLE:  taken = z_i || n_i;
      OP_JMP:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    rom_req_o = 1'b0;
    halted_o  = 1'b0;
    wracc_o   = 1'b0;
    wrram_o   = 1'b0;
    enram_o   = 1'b0;
    case (state_q)
      S_FETCH: begin
        rom_req_o = 1'b1;
        if (rom_ack_i) begin
          ir_d    = rom_data_i;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        wracc_o = wracc;
        wrram_o = wrram;
        enram_o = enram;
        if (opc == OP_HLT) begin
          state_d = S_HALT;
        end else begin
          pc_d    = taken ? ir_q[ADDR_W-1:0] : pc_q + ADDR_W'(1);
          state_d = S_FETCH;
        end
      end
      S_HALT:  halted_o = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_bip_seq_control.sv
// Bench for bip_seq_control: the bench plays the ROM and flag source, keeps a
// behavioural model of the sequencer and compares every output each cycle.
module tb_bip_seq_control;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [10:0] rom_addr_o;
  logic        rom_req_o;
  logic        rom_ack_i = 1'b0;
  logic [15:0] rom_data_i = '0;
  logic        z_i = 1'b0, n_i = 1'b0;
  logic [10:0] operand_o;
  logic [1:0]  sela_o;
  logic        selb_o, op_o, wracc_o, wrram_o, enram_o, halted_o;

  int n_vec  = 0;
  int n_fail = 0;

  // model: phase 0 = fetching, 1 = executing, 2 = halted
  int        m_phase;
  int        m_pc;
  bit [15:0] m_ir;

  always #5 clk_i = ~clk_i;

  bip_seq_control dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rom_addr_o(rom_addr_o), .rom_req_o(rom_req_o), .rom_ack_i(rom_ack_i),
    .rom_data_i(rom_data_i), .z_i(z_i), .n_i(n_i), .operand_o(operand_o),
    .sela_o(sela_o), .selb_o(selb_o), .op_o(op_o), .wracc_o(wracc_o),
    .wrram_o(wrram_o), .enram_o(enram_o), .halted_o(halted_o)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_taken(input int opc, input bit z, input bit n);
    case (opc)
      8:  return z;
      9:  return !z;
      10: return !z && !n;
      11: return !n;
      12: return n;
      13: return z || n;
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0; m_pc = 0; m_ir = '0;
  endtask

  task automatic model_step();
    int opc;
    if (!rst_i) begin model_reset(); return; end
    opc = int'(m_ir[15:11]);
    if (m_phase == 0) begin
      if (rom_ack_i) begin m_ir = rom_data_i; m_phase = 1; end
    end else if (m_phase == 1) begin
      if (opc == 0) m_phase = 2;
      else begin
        m_pc    = is_taken(opc, z_i, n_i) ? int'(m_ir[10:0]) : (m_pc + 1) % 2048;
        m_phase = 0;
      end
    end
  endtask

  task automatic compare();
    int  opc;
    bit  ex;
    int  e_sela;
    opc    = int'(m_ir[15:11]);
    ex     = (m_phase == 1);
    e_sela = (opc == 3) ? 1 : (opc >= 4 && opc <= 7) ? 2 : 0;
    chk("rom_req",  int'(rom_req_o),  int'(m_phase == 0));
    chk("rom_addr", int'(rom_addr_o), m_pc);
    chk("halted",   int'(halted_o),   int'(m_phase == 2));
    chk("operand",  int'(operand_o),  int'(m_ir[10:0]));
    chk("sela",     int'(sela_o),     e_sela);
    chk("selb",     int'(selb_o),     int'(opc == 5 || opc == 7));
    chk("op",       int'(op_o),       int'(opc == 6 || opc == 7));
    chk("wracc",    int'(wracc_o),    int'(ex && opc >= 2 && opc <= 7));
    chk("wrram",    int'(wrram_o),    int'(ex && opc == 1));
    chk("enram",    int'(enram_o),    int'(ex && (opc == 2 || opc == 4 || opc == 6)));
  endtask

  // One clock: drive inputs (called just after a negedge), advance, check.
  task automatic cyc(input bit ack, input bit [15:0] data, input bit z, input bit n);
    rom_ack_i = ack; rom_data_i = data; z_i = z; n_i = n;
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
    compare();
  endtask

  // Asynchronous reset pulse away from clock edges.
  task automatic pulse_reset();
    #2 rst_i = 1'b0;
    #1 model_reset();
    compare();
    @(negedge clk_i);
    compare();
    rst_i = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk_i);
    compare();
    chk("rst_req", int'(rom_req_o), 1);
    chk("rst_addr", int'(rom_addr_o), 0);
    rst_i = 1'b1;

    // LDI 5 acknowledged on the third request cycle
    chk("ldi_req0", int'(rom_req_o), 1);
    cyc(0, 16'h0000, 0, 0);
    chk("ldi_req1", int'(rom_req_o), 1);
    chk("ldi_addr1", int'(rom_addr_o), 0);
    cyc(0, 16'h0000, 0, 0);
    chk("ldi_req2", int'(rom_req_o), 1);
    cyc(1, 16'h1805, 0, 0);
    chk("ldi_wracc", int'(wracc_o), 1);
    chk("ldi_sela", int'(sela_o), 1);
    chk("ldi_operand", int'(operand_o), 5);
    chk("ldi_exec_req", int'(rom_req_o), 0);
    cyc(0, 16'h0000, 0, 0);
    chk("ldi_next_addr", int'(rom_addr_o), 1);

    // ADD 7, SUBI 2, zero-wait ack
    cyc(1, 16'h2007, 0, 0);
    chk("add_enram", int'(enram_o), 1);
    chk("add_selb", int'(selb_o), 0);
    chk("add_op", int'(op_o), 0);
    cyc(1, 16'h0000, 0, 0);
    chk("add_addr", int'(rom_addr_o), 2);
    cyc(1, 16'h3802, 0, 0);
    chk("subi_selb", int'(selb_o), 1);
    chk("subi_op", int'(op_o), 1);
    chk("subi_enram", int'(enram_o), 0);
    cyc(0, 16'h0000, 0, 0);
    chk("subi_addr", int'(rom_addr_o), 3);

    // branches
    cyc(1, 16'h4040, 0, 0);
    cyc(0, 16'h0000, 1, 0);
    chk("beq_taken", int'(rom_addr_o), 'h40);
    cyc(1, 16'h4040, 0, 0);
    cyc(0, 16'h0000, 0, 0);
    chk("beq_not_taken", int'(rom_addr_o), 'h41);
    cyc(1, 16'h6840, 0, 0);
    cyc(0, 16'h0000, 0, 1);
    chk("ble_taken", int'(rom_addr_o), 'h40);

    // JMP to top of ROM, then NOP wraps PC
    cyc(1, 16'h77FF, 0, 0);
    cyc(0, 16'h0000, 0, 0);
    chk("jmp_addr", int'(rom_addr_o), 'h7FF);
    cyc(1, 16'h7800, 0, 0);
    chk("nop_wracc", int'(wracc_o), 0);
    cyc(0, 16'h0000, 0, 0);
    chk("nop_wrap", int'(rom_addr_o), 0);

    // HLT is absorbing
    cyc(1, 16'h0000, 0, 0);
    cyc(0, 16'h0000, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(i[0], 16'h1805, 0, 0);
      chk("hlt_halted", int'(halted_o), 1);
      chk("hlt_req", int'(rom_req_o), 0);
    end
    pulse_reset();
    chk("hlt_rst_addr", int'(rom_addr_o), 0);
    chk("hlt_rst_halted", int'(halted_o), 0);

    // reset in EXEC of STO
    cyc(1, 16'h0805, 0, 0);
    chk("sto_wrram", int'(wrram_o), 1);
    #2 rst_i = 1'b0;
    #1 chk("sto_rst_wrram", int'(wrram_o), 0);
    chk("sto_rst_req", int'(rom_req_o), 1);
    chk("sto_rst_addr", int'(rom_addr_o), 0);
    model_reset();
    @(negedge clk_i);
    compare();
    rst_i = 1'b1;

    // randomized run
    for (int i = 0; i < 3000; i++) begin
      bit [15:0] w;
      w = 16'($urandom);
      if (m_phase == 2 && $urandom_range(0, 7) == 0) pulse_reset();
      else if ($urandom_range(0, 199) == 0) pulse_reset();
      else cyc($urandom_range(0, 1) == 1, w, $urandom_range(0, 1) == 1,
               $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/bip_seq_control.md
BIP_SEQ_CONTROL -- requirements
Module: bip_seq_control

Interface
REQ-001 Parameter INSTR_W, default 16, instruction word width.
REQ-002 Parameter OPC_W, default 5, opcode field width (instr[INSTR_W-1 -: OPC_W]); operand width OPR_W = INSTR_W-OPC_W (default 11).
REQ-003 Parameter ADDR_W, default 11, program counter / ROM address width; ADDR_W <= OPR_W, checked at elaboration.
REQ-004 clk_i  in  1  single clock, all state on rising edge.
REQ-005 rst_i  in  1  reset, asynchronous assert, active-low.
REQ-006 rom_addr_o  out  ADDR_W  fetch address (current PC).
REQ-007 rom_req_o  out  1  fetch request, held until acknowledged.
REQ-008 rom_ack_i  in  1  fetch acknowledge; rom_data_i valid in the same cycle.
REQ-009 rom_data_i  in  INSTR_W  instruction word.
REQ-010 z_i  in  1  datapath accumulator-zero flag; n_i  in  1  accumulator-negative flag.
REQ-011 operand_o  out  OPR_W  operand field of the instruction register (IR).
REQ-012 sela_o  out  2  accumulator source: 00 RAM, 01 operand, 10 ALU.
REQ-013 selb_o  out  1  ALU B source: 0 RAM, 1 operand; op_o  out  1  ALU op: 0 add, 1 sub.
REQ-014 wracc_o, wrram_o, enram_o  out  1 each  accumulator write, RAM write, RAM read enable.
REQ-015 halted_o  out  1  core stopped on HLT.

Function
REQ-016 FSM states FETCH, EXEC, HALT; encoding free.
REQ-017 FETCH: rom_req_o=1, rom_addr_o=PC; on rom_ack_i=1 IR<=rom_data_i, next state EXEC; otherwise remain, PC and IR unchanged.
REQ-018 EXEC lasts exactly one cycle; datapath strobes (wracc_o, wrram_o, enram_o) asserted only in EXEC; all three are 0 in FETCH and HALT.
REQ-019 sela_o, selb_o, op_o, operand_o decode combinationally from IR in every state.
REQ-020 Opcodes (OPC_W=5): 00000 HLT, 00001 STO, 00010 LD, 00011 LDI, 00100 ADD, 00101 ADDI, 00110 SUB, 00111 SUBI, 01000 BEQ, 01001 BNE, 01010 BGT, 01011 BGE, 01100 BLT, 01101 BLE, 01110 JMP; all others NOP.
REQ-021 STO: wrram_o=1. LD: enram_o=1, wracc_o=1, sela_o=00. LDI: wracc_o=1, sela_o=01.
REQ-022 ADD/SUB: enram_o=1, selb_o=0, sela_o=10, wracc_o=1, op_o=0/1. ADDI/SUBI: selb_o=1, sela_o=10, wracc_o=1, op_o=0/1.
REQ-023 Branch taken conditions: BEQ z; BNE !z; BGT !z&!n; BGE !n; BLT n; BLE z|n; JMP always; flags sampled in EXEC cycle.
REQ-024 End of EXEC: PC<=operand[ADDR_W-1:0] if branch taken, else PC<=PC+1 modulo 2^ADDR_W (all-ones wraps to 0); next state FETCH.
REQ-025 HLT in EXEC: PC unchanged, next state HALT; HALT absorbing until reset; halted_o=1 only in HALT; rom_req_o=0 in EXEC and HALT.
REQ-026 NOP: no strobes, PC<=PC+1, next state FETCH.
REQ-027 rom_ack_i outside FETCH ignored.

Reset
REQ-028 rst_i=0 asynchronously forces state FETCH, PC=0, IR=0; outputs then: rom_req_o=1, rom_addr_o=0, all strobes 0, halted_o=0, sela_o=00, selb_o=0, op_o=0, operand_o=0.
REQ-029 Reset mid-fetch or mid-EXEC aborts the instruction with no strobe emitted after reset assertion; first fetch after release is address 0.

Verification
REQ-030 Reset release, ROM acks after 3 cycles with LDI 5 (0x1805) -> rom_req_o high 3 cycles at addr 0, then one EXEC cycle wracc_o=1, sela_o=01, operand_o=5, then FETCH addr 1.
REQ-031 ADD 7 then SUBI 2 with 0-wait ack -> EXEC strobes enram_o=1,selb_o=0,op_o=0 then selb_o=1,op_o=1; each instruction 2 cycles.
REQ-032 BEQ 0x40 with z_i=1 -> next fetch addr 0x40; same with z_i=0 -> next fetch PC+1; repeat BLE with z_i=0,n_i=1 -> taken.
REQ-033 NOP at PC=0x7FF (ADDR_W=11) -> next fetch addr 0x000.
REQ-034 HLT -> halted_o=1, rom_req_o=0, strobes 0 for 20 cycles despite rom_ack_i toggling; rst_i pulse low -> fetch addr 0.
REQ-035 rst_i asserted in EXEC of STO -> wrram_o drops in same cycle, state FETCH, PC=0.
